// File: rtl/r5fp_idiv_radix4.sv
// Radix-4 restoring unsigned divider, responder side of the idiv strobe/done/ready handshake.
// Optional: define R5FP_IDIV_EARLY_OUT_EN to finish in one cycle when N_i < D_i.
module r5fp_idiv_radix4 #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] N_i,
  input  logic [W-1:0] D_i,
  input  logic         strobe_i,
  output logic [W-1:0] Quo_o,
  output logic [W-1:0] Rem_o,
  output logic         done_o,
  output logic         ready_o
);

  localparam int CW = (W > 3) ? $clog2(W / 2) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(W / 2 - 1);

  generate
    if ((W % 2) != 0) begin : g_w_odd
      $error("r5fp_idiv_radix4: W must be even");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    dvd_q, dvd_d;
  logic [W-1:0]    dvs_q, dvs_d;
  logic [W+1:0]    d3_q, d3_d;
  logic [W+1:0]    p_q, p_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    quo_out_q, quo_out_d;
  logic [W-1:0]    rem_out_q, rem_out_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;

  logic [W+1:0]    t_s, d1_s, d2_s, p_nxt_s;
  logic [1:0]      q_s;
  logic [W-1:0]    quo_nxt_s;
  logic            early_s;

`ifdef R5FP_IDIV_EARLY_OUT_EN
  assign early_s = (N_i < D_i);
`else
  assign early_s = 1'b0;
`endif

  // One radix-4 digit: pick the largest multiple of D not exceeding the shifted remainder
  always_comb begin
    t_s  = (p_q << 2) | {{W{1'b0}}, dvd_q[W-1:W-2]};
    d1_s = {2'b00, dvs_q};
    d2_s = {1'b0, dvs_q, 1'b0};
    if (t_s >= d3_q) begin
      q_s     = 2'd3;
      p_nxt_s = t_s - d3_q;
    end else if (t_s >= d2_s) begin
      q_s     = 2'd2;
      p_nxt_s = t_s - d2_s;
    end else if (t_s >= d1_s) begin
      q_s     = 2'd1;
      p_nxt_s = t_s - d1_s;
    end else begin
      q_s     = 2'd0;
      p_nxt_s = t_s;
    end
    quo_nxt_s = (quo_q << 2) | W'(q_s);
  end

  // Handshake FSM and datapath next-state
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    d3_d      = d3_q;
    p_d       = p_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (strobe_i) begin
          dvd_d = N_i;
          dvs_d = D_i;
          d3_d  = {2'b00, D_i} + {1'b0, D_i, 1'b0};
          p_d   = {(W+2){1'b0}};
          quo_d = {W{1'b0}};
          cnt_d = CNT_INIT;
          if (D_i == {W{1'b0}}) begin
            quo_out_d = {W{1'b1}};
            rem_out_d = N_i;
            done_d    = 1'b1;
          end else if (early_s) begin
            quo_out_d = {W{1'b0}};
            rem_out_d = N_i;
            done_d    = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        dvd_d = dvd_q << 2;
        p_d   = p_nxt_s;
        quo_d = quo_nxt_s;
        if (cnt_q == {CW{1'b0}}) begin
          // Remainder is below D here, so its top two bits are always zero
          quo_out_d = quo_nxt_s;
          rem_out_d = p_nxt_s[W-1:0];
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dvd_q     <= {W{1'b0}};
      dvs_q     <= {W{1'b0}};
      d3_q      <= {(W+2){1'b0}};
      p_q       <= {(W+2){1'b0}};
      quo_q     <= {W{1'b0}};
      cnt_q     <= {CW{1'b0}};
      quo_out_q <= {W{1'b0}};
      rem_out_q <= {W{1'b0}};
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      d3_q      <= d3_d;
      p_q       <= p_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign Quo_o   = quo_out_q;
  assign Rem_o   = rem_out_q;
  assign done_o  = done_q;
  assign ready_o = ready_q;

endmodule

// File: tb/tb_r5fp_idiv_radix4.sv
// Directed bench for r5fp_idiv_radix4 at W=8, plus a W=26 sweep against a division model.
// Latency is counted in clock edges after the accept edge (0 = done visible right after accept).
module tb_r5fp_idiv_radix4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  n8, d8, quo8, rem8;
  logic        stb8, done8, rdy8;
  logic [25:0] n26, d26, quo26, rem26;
  logic        stb26, done26, rdy26;

  int checks = 0;
  int errors = 0;

`ifdef R5FP_IDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  r5fp_idiv_radix4 #(.W(8)) u_div8 (
    .clk(clk), .reset(reset), .N_i(n8), .D_i(d8), .strobe_i(stb8),
    .Quo_o(quo8), .Rem_o(rem8), .done_o(done8), .ready_o(rdy8)
  );

  r5fp_idiv_radix4 #(.W(26)) u_div26 (
    .clk(clk), .reset(reset), .N_i(n26), .D_i(d26), .strobe_i(stb26),
    .Quo_o(quo26), .Rem_o(rem26), .done_o(done26), .ready_o(rdy26)
  );

  task automatic go8(input logic [7:0] n, input logic [7:0] d);
    n8 = n; d8 = d; stb8 = 1'b1;
    @(posedge clk); #1;
    stb8 = 1'b0;
  endtask

  task automatic wait8(output int lat, output int rdy_hi);
    lat = 0; rdy_hi = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (rdy8 === 1'b1) rdy_hi++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic go26(input logic [25:0] n, input logic [25:0] d);
    n26 = n; d26 = d; stb26 = 1'b1;
    @(posedge clk); #1;
    stb26 = 1'b0;
  endtask

  task automatic wait26(output int lat);
    lat = 0;
    while (done26 !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stb8 = 1'b0; stb26 = 1'b0;
    n8 = 8'd0; d8 = 8'd0; n26 = 26'd0; d26 = 26'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({rdy8, done8} !== 2'b10) begin
      errors++; $display("FAIL reset_hs8: ready/done got %b%b expected 10", rdy8, done8);
    end
    checks++;
    if ({quo8, rem8} !== 16'd0) begin
      errors++; $display("FAIL reset_out8: got q=%0d r=%0d expected 0/0", quo8, rem8);
    end
    checks++;
    if ({rdy26, done26, quo26, rem26} !== {1'b1, 1'b0, 52'd0}) begin
      errors++; $display("FAIL reset26: got rdy=%b done=%b q=%0d r=%0d expected 1/0/0/0",
                         rdy26, done26, quo26, rem26);
    end
  endtask

  task automatic test_basic();
    int lat, rh;
    go8(8'd200, 8'd7);
    wait8(lat, rh);
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL basic_lat: got %0d expected 4", lat);
    end
    checks++;
    if (rh != 0) begin
      errors++; $display("FAIL basic_busy_ready: ready high in %0d busy cycles, expected 0", rh);
    end
    checks++;
    if (quo8 !== 8'd28 || rem8 !== 8'd4) begin
      errors++; $display("FAIL basic_result: got q=%0d r=%0d expected q=28 r=4", quo8, rem8);
    end
    checks++;
    if (rdy8 !== 1'b1) begin
      errors++; $display("FAIL basic_ready_at_done: got %b expected 1", rdy8);
    end
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0 || quo8 !== 8'd28) begin
      errors++; $display("FAIL basic_done_pulse: got done=%b q=%0d expected done=0 q=28", done8, quo8);
    end
  endtask

  task automatic test_full_range();
    int lat, rh;
    go8(8'd255, 8'd1);
    wait8(lat, rh);
    checks++;
    if (quo8 !== 8'd255 || rem8 !== 8'd0 || lat != 4) begin
      errors++; $display("FAIL full_255_1: got q=%0d r=%0d lat=%0d expected q=255 r=0 lat=4", quo8, rem8, lat);
    end
    go8(8'd255, 8'd255);
    wait8(lat, rh);
    checks++;
    if (quo8 !== 8'd1 || rem8 !== 8'd0 || lat != 4) begin
      errors++; $display("FAIL full_255_255: got q=%0d r=%0d lat=%0d expected q=1 r=0 lat=4", quo8, rem8, lat);
    end
  endtask

  task automatic test_div_zero();
    int lat, rh;
    go8(8'd77, 8'd0);
    wait8(lat, rh);
    checks++;
    if (quo8 !== 8'hFF || rem8 !== 8'd77 || lat != 0) begin
      errors++; $display("FAIL div_zero: got q=%0d r=%0d lat=%0d expected q=255 r=77 lat=0", quo8, rem8, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat, rh, extra;
    go8(8'd200, 8'd7);
    wait8(lat, rh);
    checks++;
    if (quo8 !== 8'd28 || rem8 !== 8'd4 || lat != 4) begin
      errors++; $display("FAIL b2b_first: got q=%0d r=%0d lat=%0d expected q=28 r=4 lat=4", quo8, rem8, lat);
    end
    go8(8'd100, 8'd9);
    checks++;
    if (done8 !== 1'b0 || rdy8 !== 1'b0 || quo8 !== 8'd28) begin
      errors++; $display("FAIL b2b_accept: got done=%b ready=%b q=%0d expected done=0 ready=0 q=28",
                         done8, rdy8, quo8);
    end
    @(posedge clk); #1;
    n8 = 8'd50; d8 = 8'd3; stb8 = 1'b1;
    @(posedge clk); #1;
    stb8 = 1'b0;
    wait8(lat, rh);
    checks++;
    if (quo8 !== 8'd11 || rem8 !== 8'd1 || lat + 2 != 4) begin
      errors++; $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d expected q=11 r=1 lat=4",
                         quo8, rem8, lat + 2);
    end
    extra = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL b2b_busy_strobe: got %0d extra done pulses expected 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int extra;
    go8(8'd200, 8'd7);
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (rdy8 !== 1'b1 || done8 !== 1'b0 || quo8 !== 8'd0 || rem8 !== 8'd0) begin
      errors++; $display("FAIL abort_state: got rdy=%b done=%b q=%0d r=%0d expected 1/0/0/0",
                         rdy8, done8, quo8, rem8);
    end
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || rdy8 !== 1'b1) begin
      errors++; $display("FAIL abort_no_done: got %0d done pulses rdy=%b expected 0 and rdy=1", extra, rdy8);
    end
  endtask

  task automatic test_small_dividend();
    int lat, rh, exp_lat;
    exp_lat = EARLY ? 0 : 4;
    go8(8'd5, 8'd9);
    wait8(lat, rh);
    checks++;
    if (quo8 !== 8'd0 || rem8 !== 8'd5 || lat != exp_lat) begin
      errors++; $display("FAIL small_5_9: got q=%0d r=%0d lat=%0d expected q=0 r=5 lat=%0d",
                         quo8, rem8, lat, exp_lat);
    end
    go8(8'd0, 8'd5);
    wait8(lat, rh);
    checks++;
    if (quo8 !== 8'd0 || rem8 !== 8'd0 || lat != exp_lat) begin
      errors++; $display("FAIL zero_dividend: got q=%0d r=%0d lat=%0d expected q=0 r=0 lat=%0d",
                         quo8, rem8, lat, exp_lat);
    end
  endtask

  task automatic test_random26();
    logic [25:0] n, d, eq, er;
    logic [25:0] cn[5];
    logic [25:0] cd[5];
    int lat, exp_lat, mode;
    cn[0] = 26'h3FFFFFF; cd[0] = 26'd1;
    cn[1] = 26'h3FFFFFF; cd[1] = 26'h3FFFFFF;
    cn[2] = 26'd0;       cd[2] = 26'd1;
    cn[3] = 26'h3FFFFFF; cd[3] = 26'd3;
    cn[4] = 26'd1;       cd[4] = 26'h3FFFFFF;
    for (int i = 0; i < 2005; i++) begin
      if (i < 5) begin
        n = cn[i]; d = cd[i];
      end else begin
        n = 26'($urandom());
        mode = $urandom_range(0, 9);
        case (mode)
          0: d = 26'd0;
          1: d = 26'($urandom_range(1, 15));
          2: d = (n == 26'd0) ? 26'd1 : n;
          3: d = 26'($urandom()) >> $urandom_range(0, 25);
          default: d = 26'($urandom());
        endcase
      end
      if (d == 26'd0) begin
        eq = 26'h3FFFFFF; er = n; exp_lat = 0;
      end else begin
        eq = n / d; er = n % d;
        exp_lat = (EARLY && n < d) ? 0 : 13;
      end
      go26(n, d);
      wait26(lat);
      checks++;
      if (quo26 !== eq || rem26 !== er || lat != exp_lat) begin
        errors++;
        $display("FAIL rand26: n=%0d d=%0d got q=%0d r=%0d lat=%0d expected q=%0d r=%0d lat=%0d",
                 n, d, quo26, rem26, lat, eq, er, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_range();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    test_small_dividend();
    test_random26();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
